// File: rtl/inst_data_arbiter.sv
// Arbitrates the fetch and mem-stage requests onto a single address/data handshake bus.
// Only one bus transaction is ever outstanding, and it always runs to completion.
module inst_data_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        longest_stall,
    output logic [31:0] inst_rdata,
    output logic [31:0] data_rdata,
    output logic        i_stall,
    output logic        d_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [2:0] {IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA} state_t;

    state_t state;
    logic   inst_done, data_done;
    logic   inst_pend, data_pend, pick_data;

    assign inst_pend = inst_en & ~inst_done;
    assign data_pend = data_en & ~data_done;
    assign i_stall   = inst_pend;
    assign d_stall   = data_pend;
    assign pick_data = data_pend & (DATA_FIRST | ~inst_pend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_wstrb  <= 4'd0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_data) begin
                        state     <= D_ADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= |data_wen;
                        bus_wstrb <= data_wen;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                    end else if (inst_pend) begin
                        state     <= I_ADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_wstrb <= 4'd0;
                        bus_addr  <= inst_addr;
                        bus_wdata <= 32'd0;
                    end
                end
                // data_ok during an address phase belongs to nobody and is dropped
                D_ADDR: if (bus_addr_ok) begin
                    state   <= D_DATA;
                    bus_req <= 1'b0;
                end
                D_DATA: if (bus_data_ok) begin
                    state     <= IDLE;
                    data_done <= 1'b1;
                    if (!bus_wr) data_rdata <= bus_rdata;
                end
                I_ADDR: if (bus_addr_ok) begin
                    state   <= I_DATA;
                    bus_req <= 1'b0;
                end
                I_DATA: if (bus_data_ok) begin
                    state      <= IDLE;
                    inst_done  <= 1'b1;
                    inst_rdata <= bus_rdata;
                end
                default: state <= IDLE;
            endcase
            // Once the pipeline moves, both requesters may issue fresh accesses.
            if (!longest_stall) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end
        end
    end
endmodule
